issue_ctrl: RTL and testbench
=============================

Name: issue_ctrl

Overview:
- Dual-issue scheduler sitting between the ID-stage instruction FIFO and the EX-bound issue bus.
- Each cycle it inspects the two FIFO head entries plus pipeline hazard state, and decides whether to issue none, one or two instructions. It drives the FIFO pop handshake (issue_i / issue_mode_i) and the per-slot valid bits.
- It keeps a branch/delay-slot pairing FSM, raises load-use and FIFO back-pressure stall requests, and counts issue statistics.

Parameters:
- FIFO_DEPTH, 16, entry count of the instruction FIFO.
- CNT_W, 5, width of fifo_count (log2(FIFO_DEPTH)+1).
- FULL_MARGIN, 4; stallreq_for_fifo is asserted when free entries are at or below this value.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush (exception/eret)
- stall  in  StallBus  pipeline stall vector; stall[2]==Stop blocks issue
- fifo_count  in  CNT_W  valid entries in FIFO
- i1_rs, i1_rt, i2_rs, i2_rt  in  5 each  head source register numbers
- i1_rd_rs, i1_rd_rt, i2_rd_rs, i2_rd_rt  in  1 each  source actually read (sel_src[0])
- i1_we, i2_we  in  1 each  head writes GPR
- i1_waddr, i2_waddr  in  5 each  head destination
- i1_flag, i2_flag  in  3 each  resource class (0 = plain ALU; nonzero = mem/hilo/cp0, one per pair)
- i1_is_br, i2_is_br  in  1 each  head is branch/jump
- ex_is_load  in  1  instruction in EX is a load
- ex_waddr  in  5  its destination
- issue  out  1  pop FIFO this cycle
- issue_mode  out  1  SingleIssue / DualIssue (defines encoding)
- inst1_valid, inst2_valid  out  1 each  slot valid to EX
- stallreq_for_load  out  1  load-use stall request
- stallreq_for_fifo  out  1  FIFO near-full request to IF
- issued_cnt, dual_cnt  out  32 each  statistics counters

Behaviour:
- Reset: state=NORMAL; issue=0; inst1_valid=inst2_valid=0; stallreq_for_load=0; stallreq_for_fifo=0; counters=0.
- Issue decision is combinational in the same cycle as the FIFO head is presented. The FIFO pops on the next clk edge when issue=1.
- Blocked (issue=0, both valids 0) when any of these hold: rst, flush, stall[2]==Stop, fifo_count==0, load-use on inst1.
- Load-use: ex_is_load & ex_waddr!=0 & ((i1_rd_rs & i1_rs==ex_waddr) | (i1_rd_rt & i1_rt==ex_waddr)).
  - stallreq_for_load=1 in that cycle; no issue.
  - If the load-use hits only inst2, issue inst1 single.
- Dual allowed only when all hold: fifo_count>=2; no RAW/WAW between slots (i1_we & i1_waddr matched against inst2 sources or i2_waddr, waddr!=0); not (i1_flag!=0 & i2_flag!=0); i2_is_br==0; inst2 not load-use.
- FSM states:
  - NORMAL:
    - If i1_is_br and fifo_count>=2 and dual allowed: dual issue the branch + delay slot, stay NORMAL.
    - If i1_is_br and the delay slot is not dual-issuable (count==1 or hazard): single issue the branch, go to WAIT_DS.
    - Otherwise: dual if allowed, else single.
  - WAIT_DS:
    - Only the delay slot may issue, always single, once fifo_count>=1 and there is no load-use. Then return to NORMAL.
    - issue held 0 while fifo_count==0.
    - stall holds the state.
- flush wins over everything: next state NORMAL, no issue that cycle. This includes flush during WAIT_DS.
- Outputs on issue:
  - inst1_valid=1.
  - inst2_valid=1 only for DualIssue.
  - issue_mode=SingleIssue whenever issue=0.
- stallreq_for_fifo is registered: next value = (FIFO_DEPTH - fifo_count) <= FULL_MARGIN. Cleared by rst and flush.
- Counters on each issue:
  - issued_cnt += 1 for single, += 2 for dual.
  - dual_cnt += 1 on dual.
  - Both wrap at 2^32 and are unaffected by flush.

Decomposition:
- Shared defines file: SingleIssue/DualIssue encodings, StallBus width, Stop/NoStop, and the FSM state encodings ISSUE_NORMAL / ISSUE_WAIT_DS.
- One natural sub-module, issue_hazard_chk: purely combinational; computes load-use per slot and the inter-slot dependency/conflict. Instantiated once.
- FSM, stall register and counters live in issue_ctrl.

Test Plan:
- Independent pair: count=4, i1 writes r3, i2 reads r5/r6, flags 0 → issue=1, mode=Dual, both valids 1, dual_cnt 0→1, issued_cnt 0→2.
- RAW pair: i1 writes r8, i2 reads rs=r8 → mode=Single, inst2_valid=0. Same pair with i1_waddr=0 → Dual.
- Load-use: ex_is_load=1, ex_waddr=r4, i1 reads rt=r4 → issue=0, stallreq_for_load=1. Next cycle ex_is_load=0 → issues.
- Branch with missing delay slot: i1_is_br=1, count=1 → single issue, state WAIT_DS. Next two cycles count=0 → issue=0. Then count=2 → single issue, back to NORMAL.
- Flush in WAIT_DS with count=3 → issue=0 that cycle, state NORMAL, stallreq_for_fifo=0 next cycle.
- Back-pressure: count=12 with DEPTH=16, MARGIN=4 → stallreq_for_fifo=1 one cycle later. Count=11 → 0 one cycle later. rst mid-run → all outputs and counters 0 after the edge.

Source files
------------

// File: rtl/issue_ctrl_pkg.sv
// Shared encodings for the dual-issue scheduler: issue modes, stall bus and FSM states.
package issue_ctrl_pkg;

  localparam int   STALL_W = 6;
  localparam logic Stop    = 1'b1;
  localparam logic NoStop  = 1'b0;

  typedef enum logic {
    SingleIssue = 1'b0,
    DualIssue   = 1'b1
  } issue_mode_e;

  typedef enum logic {
    ISSUE_NORMAL  = 1'b0,
    ISSUE_WAIT_DS = 1'b1
  } issue_state_e;

  function automatic logic reads_reg(input logic rd_en, input logic [4:0] src,
                                     input logic [4:0] reg_num);
    return rd_en && (src == reg_num);
  endfunction

endpackage

// File: rtl/issue_hazard_chk.sv
// Combinational hazard detection for the two FIFO head slots: load-use per slot
// plus the inter-slot register dependency and shared-resource conflict.
module issue_hazard_chk
  import issue_ctrl_pkg::*;
(
  input  logic       i1_rd_rs,
  input  logic       i1_rd_rt,
  input  logic [4:0] i1_rs,
  input  logic [4:0] i1_rt,
  input  logic       i1_we,
  input  logic [4:0] i1_waddr,
  input  logic [2:0] i1_flag,
  input  logic       i2_rd_rs,
  input  logic       i2_rd_rt,
  input  logic [4:0] i2_rs,
  input  logic [4:0] i2_rt,
  input  logic       i2_we,
  input  logic [4:0] i2_waddr,
  input  logic [2:0] i2_flag,
  input  logic       ex_is_load,
  input  logic [4:0] ex_waddr,
  output logic       load_use1,
  output logic       load_use2,
  output logic       slot_dep,
  output logic       res_conflict
);

  logic ex_load_live;

  always_comb begin
    ex_load_live = ex_is_load && (ex_waddr != '0);
    load_use1 = ex_load_live &&
                (reads_reg(i1_rd_rs, i1_rs, ex_waddr) || reads_reg(i1_rd_rt, i1_rt, ex_waddr));
    load_use2 = ex_load_live &&
                (reads_reg(i2_rd_rs, i2_rs, ex_waddr) || reads_reg(i2_rd_rt, i2_rt, ex_waddr));
    // r0 is never a real destination, so writes to it create no RAW/WAW ordering.
    slot_dep = i1_we && (i1_waddr != '0) &&
               (reads_reg(i2_rd_rs, i2_rs, i1_waddr) ||
                reads_reg(i2_rd_rt, i2_rt, i1_waddr) ||
                (i2_we && (i2_waddr == i1_waddr)));
    res_conflict = (i1_flag != '0) && (i2_flag != '0);
  end

endmodule

// File: rtl/issue_ctrl.sv
// Dual-issue scheduler between the ID instruction FIFO and the EX issue bus:
// branch/delay-slot pairing FSM, stall requests and issue statistics.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = 5,
  parameter int FULL_MARGIN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [STALL_W-1:0] stall,
  input  logic [CNT_W-1:0]   fifo_count,
  input  logic [4:0]         i1_rs,
  input  logic [4:0]         i1_rt,
  input  logic [4:0]         i2_rs,
  input  logic [4:0]         i2_rt,
  input  logic               i1_rd_rs,
  input  logic               i1_rd_rt,
  input  logic               i2_rd_rs,
  input  logic               i2_rd_rt,
  input  logic               i1_we,
  input  logic               i2_we,
  input  logic [4:0]         i1_waddr,
  input  logic [4:0]         i2_waddr,
  input  logic [2:0]         i1_flag,
  input  logic [2:0]         i2_flag,
  input  logic               i1_is_br,
  input  logic               i2_is_br,
  input  logic               ex_is_load,
  input  logic [4:0]         ex_waddr,
  output logic               issue,
  output logic               issue_mode,
  output logic               inst1_valid,
  output logic               inst2_valid,
  output logic               stallreq_for_load,
  output logic               stallreq_for_fifo,
  output logic [31:0]        issued_cnt,
  output logic [31:0]        dual_cnt
);

  localparam logic [CNT_W-1:0] FULL_THRESH = CNT_W'(FIFO_DEPTH - FULL_MARGIN);

  issue_state_e state_q, state_d;
  issue_mode_e  mode;
  logic         load_use1, load_use2, slot_dep, res_conflict;
  logic         head_empty, blocked, dual_ok;
  logic         unused_stall_bits;

  assign unused_stall_bits = ^{stall[STALL_W-1:3], stall[1:0]};

  issue_hazard_chk u_hazard (
    .i1_rd_rs     (i1_rd_rs),
    .i1_rd_rt     (i1_rd_rt),
    .i1_rs        (i1_rs),
    .i1_rt        (i1_rt),
    .i1_we        (i1_we),
    .i1_waddr     (i1_waddr),
    .i1_flag      (i1_flag),
    .i2_rd_rs     (i2_rd_rs),
    .i2_rd_rt     (i2_rd_rt),
    .i2_rs        (i2_rs),
    .i2_rt        (i2_rt),
    .i2_we        (i2_we),
    .i2_waddr     (i2_waddr),
    .i2_flag      (i2_flag),
    .ex_is_load   (ex_is_load),
    .ex_waddr     (ex_waddr),
    .load_use1    (load_use1),
    .load_use2    (load_use2),
    .slot_dep     (slot_dep),
    .res_conflict (res_conflict)
  );

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    mode       = SingleIssue;
    head_empty = (fifo_count == '0);
    blocked    = rst || flush || (stall[2] == Stop) || head_empty || load_use1;
    dual_ok    = (fifo_count >= CNT_W'(2)) && !slot_dep && !res_conflict &&
                 !i2_is_br && !load_use2;

    if (flush) begin
      state_d = ISSUE_NORMAL;
    end else if (!blocked) begin
      issue = 1'b1;
      unique case (state_q)
        ISSUE_NORMAL: begin
          // A branch that cannot take its delay slot along waits for it alone.
          if (dual_ok)       mode    = DualIssue;
          else if (i1_is_br) state_d = ISSUE_WAIT_DS;
        end
        ISSUE_WAIT_DS: state_d = ISSUE_NORMAL;
        default:       state_d = ISSUE_NORMAL;
      endcase
    end

    issue_mode        = mode;
    inst1_valid       = issue;
    inst2_valid       = issue && (mode == DualIssue);
    stallreq_for_load = !rst && !flush && !head_empty && load_use1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ISSUE_NORMAL;
      stallreq_for_fifo <= 1'b0;
      issued_cnt        <= '0;
      dual_cnt          <= '0;
    end else begin
      state_q           <= state_d;
      stallreq_for_fifo <= !flush && (fifo_count >= FULL_THRESH);
      if (issue) begin
        issued_cnt <= issued_cnt + ((mode == DualIssue) ? 32'd2 : 32'd1);
        if (mode == DualIssue) dual_cnt <= dual_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural scheduler model.
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  logic               clk;
  logic               rst, flush;
  logic [STALL_W-1:0] stall;
  logic [4:0]         fifo_count;
  logic [4:0]         i1_rs, i1_rt, i2_rs, i2_rt;
  logic               i1_rd_rs, i1_rd_rt, i2_rd_rs, i2_rd_rt;
  logic               i1_we, i2_we;
  logic [4:0]         i1_waddr, i2_waddr;
  logic [2:0]         i1_flag, i2_flag;
  logic               i1_is_br, i2_is_br;
  logic               ex_is_load;
  logic [4:0]         ex_waddr;
  logic               issue, issue_mode, inst1_valid, inst2_valid;
  logic               stallreq_for_load, stallreq_for_fifo;
  logic [31:0]        issued_cnt, dual_cnt;

  int checks = 0;
  int errors = 0;
  int step   = 0;

  // Model state: waiting for a delay slot, registered near-full flag, statistics.
  bit          m_wait_ds;
  bit          m_fifo_req;
  logic [31:0] m_issued, m_dual;

  issue_ctrl #(.FIFO_DEPTH(16), .CNT_W(5), .FULL_MARGIN(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .fifo_count(fifo_count),
    .i1_rs(i1_rs), .i1_rt(i1_rt), .i2_rs(i2_rs), .i2_rt(i2_rt),
    .i1_rd_rs(i1_rd_rs), .i1_rd_rt(i1_rd_rt), .i2_rd_rs(i2_rd_rs), .i2_rd_rt(i2_rd_rt),
    .i1_we(i1_we), .i2_we(i2_we), .i1_waddr(i1_waddr), .i2_waddr(i2_waddr),
    .i1_flag(i1_flag), .i2_flag(i2_flag), .i1_is_br(i1_is_br), .i2_is_br(i2_is_br),
    .ex_is_load(ex_is_load), .ex_waddr(ex_waddr),
    .issue(issue), .issue_mode(issue_mode), .inst1_valid(inst1_valid),
    .inst2_valid(inst2_valid), .stallreq_for_load(stallreq_for_load),
    .stallreq_for_fifo(stallreq_for_fifo), .issued_cnt(issued_cnt), .dual_cnt(dual_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step %0d: observed %0h expected %0h", tag, step, obs, exp);
    end
  endtask

  function automatic bit hits_load(input bit rd_rs, input int rs, input bit rd_rt, input int rt);
    int w = int'(ex_waddr);
    if (!ex_is_load || w == 0) return 0;
    return (rd_rs && rs == w) || (rd_rt && rt == w);
  endfunction

  // How many instructions leave the FIFO this cycle: 0, 1 or 2.
  function automatic int model_issue_count();
    bit lu1, lu2, dep;
    int w1;
    lu1 = hits_load(i1_rd_rs, int'(i1_rs), i1_rd_rt, int'(i1_rt));
    lu2 = hits_load(i2_rd_rs, int'(i2_rs), i2_rd_rt, int'(i2_rt));
    if (rst || flush || stall[2] || fifo_count == 0 || lu1) return 0;
    if (m_wait_ds) return 1;
    w1  = int'(i1_waddr);
    dep = i1_we && w1 != 0 &&
          ((i2_rd_rs && int'(i2_rs) == w1) || (i2_rd_rt && int'(i2_rt) == w1) ||
           (i2_we && int'(i2_waddr) == w1));
    if (fifo_count >= 2 && !dep && !(i1_flag != 0 && i2_flag != 0) && !i2_is_br && !lu2)
      return 2;
    return 1;
  endfunction

  task automatic tick();
    int n;
    bit lu_req;
    #1;
    step++;
    n      = model_issue_count();
    lu_req = !rst && !flush && fifo_count != 0 &&
             hits_load(i1_rd_rs, int'(i1_rs), i1_rd_rt, int'(i1_rt));
    chk("issue",             issue,             32'(n > 0));
    chk("issue_mode",        issue_mode,        32'(n == 2));
    chk("inst1_valid",       inst1_valid,       32'(n > 0));
    chk("inst2_valid",       inst2_valid,       32'(n == 2));
    chk("stallreq_for_load", stallreq_for_load, 32'(lu_req));
    chk("stallreq_for_fifo", stallreq_for_fifo, 32'(m_fifo_req));
    chk("issued_cnt",        issued_cnt,        m_issued);
    chk("dual_cnt",          dual_cnt,          m_dual);
    @(posedge clk);
    if (rst) begin
      m_wait_ds = 0; m_fifo_req = 0; m_issued = '0; m_dual = '0;
    end else begin
      m_fifo_req = !flush && (16 - int'(fifo_count)) <= 4;
      m_issued   = m_issued + 32'(n);
      if (n == 2) m_dual = m_dual + 1;
      if (flush)                            m_wait_ds = 0;
      else if (n == 1 && m_wait_ds)         m_wait_ds = 0;
      else if (n == 1 && i1_is_br)          m_wait_ds = 1;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs(input int count);
    rst = 0; flush = 0; stall = '0; fifo_count = 5'(count);
    i1_rs = '0; i1_rt = '0; i2_rs = '0; i2_rt = '0;
    i1_rd_rs = 0; i1_rd_rt = 0; i2_rd_rs = 0; i2_rd_rt = 0;
    i1_we = 0; i2_we = 0; i1_waddr = '0; i2_waddr = '0;
    i1_flag = '0; i2_flag = '0; i1_is_br = 0; i2_is_br = 0;
    ex_is_load = 0; ex_waddr = '0;
  endtask

  task automatic independent_pair(input int count);
    clear_inputs(count);
    i1_we = 1; i1_waddr = 5'd3;
    i2_rs = 5'd5; i2_rt = 5'd6; i2_rd_rs = 1; i2_rd_rt = 1;
  endtask

  task automatic random_inputs();
    rst        = ($urandom_range(0, 99) == 0);
    flush      = ($urandom_range(0, 19) == 0);
    stall      = STALL_W'($urandom);
    stall[2]   = ($urandom_range(0, 9) == 0);
    fifo_count = 5'($urandom_range(0, 16));
    i1_rs = 5'($urandom_range(0, 7)); i1_rt = 5'($urandom_range(0, 7));
    i2_rs = 5'($urandom_range(0, 7)); i2_rt = 5'($urandom_range(0, 7));
    i1_rd_rs = 1'($urandom); i1_rd_rt = 1'($urandom);
    i2_rd_rs = 1'($urandom); i2_rd_rt = 1'($urandom);
    i1_we = 1'($urandom); i2_we = 1'($urandom);
    i1_waddr = 5'($urandom_range(0, 7)); i2_waddr = 5'($urandom_range(0, 7));
    i1_flag = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    i2_flag = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    i1_is_br = ($urandom_range(0, 4) == 0);
    i2_is_br = ($urandom_range(0, 5) == 0);
    ex_is_load = ($urandom_range(0, 2) == 0);
    ex_waddr   = 5'($urandom_range(0, 7));
  endtask

  initial begin
    m_wait_ds = 0; m_fifo_req = 0; m_issued = '0; m_dual = '0;
    clear_inputs(0);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    tick();
    tick();

    // Independent pair, then RAW pair, then the same pair writing r0.
    independent_pair(4);
    tick();
    clear_inputs(4);
    i1_we = 1; i1_waddr = 5'd8; i2_rs = 5'd8; i2_rd_rs = 1;
    tick();
    i1_waddr = 5'd0;
    tick();

    // Load-use on inst1, then the load leaves EX.
    independent_pair(4);
    i1_rt = 5'd4; i1_rd_rt = 1; ex_is_load = 1; ex_waddr = 5'd4;
    tick();
    ex_is_load = 0;
    tick();

    // Branch without its delay slot, slot arrives two cycles later.
    clear_inputs(1);
    i1_is_br = 1;
    tick();
    clear_inputs(0);
    tick();
    tick();
    independent_pair(2);
    tick();
    tick();

    // Flush while waiting for the delay slot.
    clear_inputs(1);
    i1_is_br = 1;
    tick();
    independent_pair(3);
    flush = 1;
    tick();
    flush = 0;
    tick();

    // FIFO back-pressure threshold, registered one cycle late.
    clear_inputs(12);
    stall[2] = Stop;
    tick();
    tick();
    fifo_count = 5'd11;
    tick();
    tick();

    // Reset in the middle of a run.
    independent_pair(5);
    tick();
    rst = 1;
    tick();
    clear_inputs(0);
    tick();

    for (int i = 0; i < 600; i++) begin
      random_inputs();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
